// File: rtl/delay_timer.sv
// delay_timer: START/RDY responder that counts a programmable delay on a prescaled tick and pulses RDY on expiry.
module delay_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             START,
  input  logic [WIDTH-1:0] DELAY,
  input  logic             ABORT,
  output logic             RDY,
  output logic             BUSY,
  output logic [WIDTH-1:0] COUNT,
  output logic             ERR
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0] pc_q, pc_d;
  logic err_q, err_d;
  logic tick, last;
  assign tick = pc_q == PW'(PRESCALE - 1);
  assign last = tick && count_q == WIDTH'(1);
  always_comb begin
    state_d = IDLE;
    count_d = '0;
    pc_d    = '0;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: if (START && !ABORT) begin
        state_d = DELAY != '0 ? RUN : DONE;
        count_d = DELAY;
        err_d   = 1'b0;
      end
      RUN: if (!ABORT) begin
        state_d = last ? DONE : RUN;
        count_d = tick && count_q != '0 ? count_q - 1'b1 : count_q;
        pc_d    = tick ? '0 : pc_q + 1'b1;
        err_d   = err_q | START;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  assign RDY   = state_q == DONE;
  assign BUSY  = state_q == RUN;
  assign COUNT = count_q;
  assign ERR   = err_q;
endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: directed checks of delay_timer at PRESCALE=1 (instance a) and PRESCALE=3 (instance b).
module tb_delay_timer;
  logic clk = 1'b0, reset = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [15:0] delay_a = '0, delay_b = '0, count_a, count_b;
  logic rdy_a, busy_a, err_a, rdy_b, busy_b, err_b;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  delay_timer #(.WIDTH(16), .PRESCALE(1)) u_a (
    .clk(clk), .reset(reset), .START(start_a), .DELAY(delay_a), .ABORT(abort_a),
    .RDY(rdy_a), .BUSY(busy_a), .COUNT(count_a), .ERR(err_a));
  delay_timer #(.WIDTH(16), .PRESCALE(3)) u_b (
    .clk(clk), .reset(reset), .START(start_b), .DELAY(delay_b), .ABORT(abort_b),
    .RDY(rdy_b), .BUSY(busy_b), .COUNT(count_b), .ERR(err_b));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_a(input string tag, input logic rdy, input logic busy, input logic [15:0] cnt, input logic err);
    chk({tag, ".rdy"}, 32'(rdy_a), 32'(rdy));
    chk({tag, ".busy"}, 32'(busy_a), 32'(busy));
    chk({tag, ".count"}, 32'(count_a), 32'(cnt));
    chk({tag, ".err"}, 32'(err_a), 32'(err));
  endtask
  initial begin
    #1;
    chk_a("reset_a", 0, 0, 0, 0);
    chk("reset_b", {rdy_b, busy_b, err_b, count_b}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    // DELAY=5, PRESCALE=1
    delay_a = 16'd5; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_a($sformatf("d5_run%0d", i), 0, 1, 16'(5 - i), 0);
      tick();
    end
    chk_a("d5_done", 1, 0, 0, 0);
    tick();
    chk_a("d5_idle", 0, 0, 0, 0);
    tick();
    chk_a("d5_idle2", 0, 0, 0, 0);
    // PRESCALE=3, DELAY=4
    delay_b = 16'd4; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("p3_count%0d", c), 32'(count_b), 32'(4 - c / 3));
      chk($sformatf("p3_busy%0d", c), {rdy_b, busy_b}, 32'b01);
      tick();
    end
    chk("p3_done", {rdy_b, busy_b, count_b}, {2'b10, 16'd0});
    tick();
    chk("p3_idle", {rdy_b, busy_b}, 32'b00);
    // DELAY=0
    delay_a = 16'd0; start_a = 1'b1;
    chk("d0_pre_busy", 32'(busy_a), 32'd0);
    tick();
    start_a = 1'b0;
    chk_a("d0_done", 1, 0, 0, 0);
    tick();
    chk_a("d0_idle", 0, 0, 0, 0);
    // ABORT together with START in IDLE is ignored
    delay_a = 16'd3; start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    chk_a("abort_idle", 0, 0, 0, 0);
    // DELAY=6, ABORT at cycle 3
    delay_a = 16'd6; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    chk_a("ab_pre", 0, 1, 4, 0);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk_a("ab_post", 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ab_nordy%0d", i), {rdy_a, busy_a}, 32'b00);
      tick();
    end
    delay_a = 16'd2; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk_a("ab_d2_0", 0, 1, 2, 0);
    tick();
    chk_a("ab_d2_1", 0, 1, 1, 0);
    tick();
    chk_a("ab_d2_done", 1, 0, 0, 0);
    tick();
    // Overrun during RUN, then back-to-back restart in the RDY cycle
    delay_a = 16'd8; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    delay_a = 16'd3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk_a("ov_err", 0, 1, 5, 1);
    for (int i = 0; i < 4; i++) tick();
    chk_a("ov_last", 0, 1, 1, 1);
    tick();
    chk_a("ov_done", 1, 0, 0, 1);
    delay_a = 16'd3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk_a("b2b_0", 0, 1, 3, 0);
    tick();
    chk_a("b2b_1", 0, 1, 2, 0);
    tick();
    chk_a("b2b_2", 0, 1, 1, 0);
    tick();
    chk_a("b2b_done", 1, 0, 0, 0);
    tick();
    chk_a("b2b_idle", 0, 0, 0, 0);
    // Reset mid-RUN
    delay_a = 16'd6; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    chk_a("rst_pre", 0, 1, 4, 0);
    #2 reset = 1'b0;
    #1;
    chk_a("rst_async", 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst_nordy%0d", i), {rdy_a, busy_a, count_a}, 32'd0);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
